// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - fetch, data-access and byte-wide RAM bus signals of mem_ctrl
interface mem_ctrl_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] inst_o;
   logic        if_done;

   logic        load_or_not;
   logic        store_or_not;
   logic [31:0] mem_addr_i;
   logic [2:0]  num_of_bytes;
   logic [31:0] store_data;
   logic [31:0] load_data;
   logic        mem_enable;

   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;

   // The controller side.
   modport slave (
      input  if_req, if_addr, load_or_not, store_or_not, mem_addr_i,
             num_of_bytes, store_data, ram_din,
      output inst_o, if_done, load_data, mem_enable, ram_dout, ram_a, ram_wr
   );

   // The requesters and the RAM.
   modport master (
      output if_req, if_addr, load_or_not, store_or_not, mem_addr_i,
             num_of_bytes, store_data, ram_din,
      input  inst_o, if_done, load_data, mem_enable, ram_dout, ram_a, ram_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates MEM loads/stores against IF fetches and serialises
// each access into little-endian byte transactions on an 8-bit RAM bus
module mem_ctrl (
   input  logic      clk,
   input  logic      rst,
   input  logic      rdy,
   mem_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  n_q, n_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] cap_q, cap_d;
   logic [31:0] ram_a_q, ram_a_d;
   logic [7:0]  ram_dout_q, ram_dout_d;
   logic        ram_wr_q, ram_wr_d;
   logic [31:0] load_data_q, load_data_d;
   logic [31:0] inst_q, inst_d;
   logic        mem_en_q, mem_en_d;
   logic        if_done_q, if_done_d;

   logic        accept;
   logic [2:0]  nxt;
   logic [2:0]  req_n;
   logic [31:0] req_addr;
   logic [31:0] assembled;

   // A done output still high means the request being retired is still asserted.
   assign accept = (state_q == IDLE) && !if_done_q && !mem_en_q
                   && (bus.load_or_not || bus.store_or_not || bus.if_req);

   assign nxt = cnt_q + 3'd1;

   always_comb begin
      req_n    = 3'd4;
      req_addr = bus.if_addr;
      if (bus.load_or_not || bus.store_or_not) begin
         req_addr = bus.mem_addr_i;
         case (bus.num_of_bytes)
            3'd1:    req_n = 3'd1;
            3'd2:    req_n = 3'd2;
            default: req_n = 3'd4;
         endcase
      end
   end

   // ram_din now carries byte cnt_q-1, whose address went out two edges ago.
   assign assembled = (cnt_q == 3'd0) ? cap_q
                      : (cap_q | ({24'd0, bus.ram_din} << {cnt_q - 3'd1, 3'b000}));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.load_or_not)       state_d = LOAD;
               else if (bus.store_or_not) state_d = STORE;
               else                       state_d = FETCH;
            end
         end
         LOAD, FETCH: if (cnt_q == n_q) state_d = IDLE;
         STORE:       if (nxt == n_q)   state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      n_d         = n_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      cap_d       = cap_q;
      ram_a_d     = ram_a_q;
      ram_dout_d  = ram_dout_q;
      ram_wr_d    = 1'b0;
      load_data_d = load_data_q;
      inst_d      = inst_q;
      mem_en_d    = 1'b0;
      if_done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = 3'd0;
               n_d     = req_n;
               base_d  = req_addr;
               wdata_d = bus.store_data;
               cap_d   = '0;
               ram_a_d = req_addr;
               if (!bus.load_or_not && bus.store_or_not) begin
                  ram_dout_d = bus.store_data[7:0];
                  ram_wr_d   = 1'b1;
               end
            end
         end
         LOAD, FETCH: begin
            cnt_d = nxt;
            cap_d = assembled;
            if (nxt < n_q) ram_a_d = base_q + {29'd0, nxt};
            if (cnt_q == n_q) begin
               if (state_q == LOAD) begin
                  load_data_d = assembled;
                  mem_en_d    = 1'b1;
               end else begin
                  inst_d    = assembled;
                  if_done_d = 1'b1;
               end
            end
         end
         STORE: begin
            cnt_d = nxt;
            if (nxt == n_q) begin
               mem_en_d = 1'b1;
            end else begin
               ram_a_d    = base_q + {29'd0, nxt};
               ram_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
               ram_wr_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     state_q <= IDLE;
      else if (rdy) state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         n_q         <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         cap_q       <= '0;
         ram_a_q     <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
         load_data_q <= '0;
         inst_q      <= '0;
         mem_en_q    <= 1'b0;
         if_done_q   <= 1'b0;
      end else if (rdy) begin
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         cap_q       <= cap_d;
         ram_a_q     <= ram_a_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
         load_data_q <= load_data_d;
         inst_q      <= inst_d;
         mem_en_q    <= mem_en_d;
         if_done_q   <= if_done_d;
      end
   end

   // A write held across a stall must not commit until rdy returns.
   assign bus.ram_wr     = ram_wr_q & rdy;
   assign bus.ram_a      = ram_a_q;
   assign bus.ram_dout   = ram_dout_q;
   assign bus.inst_o     = inst_q;
   assign bus.if_done    = if_done_q;
   assign bus.load_data  = load_data_q;
   assign bus.mem_enable = mem_en_q;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the MEM stage and instruction fetch on one side and the byte-wide RAM bus on the other. It arbitrates one 1/2/4-byte data load or store from MEM against 4-byte instruction fetches from IF, serialises each access into little-endian byte transactions, and returns assembled data with a one-cycle done pulse. Only one access is in flight at a time.

## Interface
- No parameters. Data and address are 32 bits. The RAM bus is 8 bits.
- clk  in  1  system clock; all registers update on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes the block. The RAM also stalls on rdy low, so ram_din holds.
- if_req  in  1  fetch request, held until if_done.
- if_addr  in  32  fetch address.
- inst_o  out  32  fetched instruction; valid while if_done=1.
- if_done  out  1  one-cycle fetch-complete pulse.
- load_or_not  in  1  MEM load request, held until mem_enable.
- store_or_not  in  1  MEM store request, held until mem_enable.
- mem_addr_i  in  32  data address.
- num_of_bytes  in  3  access size: 1, 2 or 4.
- store_data  in  32  store value in the low bytes.
- load_data  out  32  load result, zero-extended; valid while mem_enable=1.
- mem_enable  out  1  one-cycle data-access-complete pulse.
- ram_din  in  8  RAM read data, one cycle after the address.
- ram_dout  out  8  RAM write data.
- ram_a  out  32  RAM byte address.
- ram_wr  out  1  1 = write, 0 = read.

## Operation
- States:
  - IDLE: no access in flight.
  - LOAD: data load in progress.
  - STORE: data store in progress.
  - FETCH: instruction fetch in progress.
- Acceptance happens on a rising edge in IDLE with rdy=1 and both done outputs low.
  - Priority order: load, then store, then fetch.
  - MEM requests always beat a pending fetch, which waits.
- The edge where if_done or mem_enable is high never accepts a request. This prevents re-accepting the request being retired.
- Size N:
  - num_of_bytes=1 gives N=1; num_of_bytes=2 gives N=2.
  - Any other num_of_bytes value gives N=4.
  - Fetch always uses N=4.
- Byte k uses address base+k, with 32-bit wrap-around (0xFFFFFFFF+1 = 0).
- Byte k of the data occupies bits [8k+7:8k] (little-endian).
- A 3-bit byte counter indexes issue and capture.
- LOAD/FETCH:
  - Issue addresses base+0 to base+N-1 on consecutive cycles with ram_wr=0.
  - Capture each ram_din byte one cycle after its address.
  - Bytes at index N and above read as 0.
- STORE:
  - Drive ram_a=base+k, ram_dout=store_data byte k, ram_wr=1 for N consecutive cycles.
  - Then return ram_wr to 0.
- Completion:
  - Register the assembled word onto load_data or inst_o.
  - Pulse the matching done output for exactly one cycle, then return to IDLE.
  - load_data and inst_o hold their last value afterwards.
- rdy=0:
  - All state, counter, captured bytes and outputs hold.
  - The effective ram_wr is ram_wr & rdy, so no write is committed during a stall. The held byte is written once rdy returns.
- Reset (asynchronous, at any time including mid-access):
  - State goes to IDLE and the counter to 0.
  - Outputs go to zero: inst_o=0, load_data=0, if_done=0, mem_enable=0, ram_a=0, ram_dout=0, ram_wr=0.
  - A partial access is discarded and no done pulse is issued.

## Timing
- E0 is the accepting edge. After edge Ek, ram_a=base+k for k<N.
- Load/fetch:
  - Byte k is captured at E(k+2).
  - Done is high in the cycle after E(N+1).
  - Latency from request seen to done: N+2 cycles (1B: 3, 2B: 4, 4B: 6).
- Store:
  - Byte k is written in the cycle after Ek.
  - Done is high in the cycle after EN (1B: 2, 4B: 5).
- Earliest next acceptance is the edge ending the done cycle +1, i.e. after one idle cycle.
- Each rdy-low cycle adds exactly one cycle to any latency and does not reorder bytes.

## Test plan
- Reset then fetch: RAM[0x100..0x103]=13 05 A0 00, if_req, if_addr=0x100 -> if_done pulse 6 cycles later, inst_o=0x00A00513, ram_wr never 1.
- Load-halfword: RAM[0x2001]=0x34, RAM[0x2002]=0x92, load, num_of_bytes=2, addr 0x2001 -> mem_enable after 4 cycles, load_data=0x00009234, exactly one pulse.
- Store-word then load-word: store 0xDEADBEEF to 0x40 -> bytes EF BE AD DE at 0x40..0x43 with ram_wr high exactly 4 cycles; a following 4-byte load at 0x40 returns 0xDEADBEEF.
- Simultaneous if_req and store_or_not in IDLE -> store served first; fetch accepted one idle cycle after mem_enable; if_done follows 6 cycles later.
- Mid-access disruption: deassert rdy for 3 cycles during the 2nd store byte -> no ram_wr during the stall, all bytes correct, done delayed by 3; assert rst during a 4-byte load -> all outputs 0 immediately, no done pulse, next fetch correct.
